// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter / fetch-control stage.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_e;

    localparam int         PC_W_DEF       = 8;
    localparam int         CNT_W_DEF      = 16;
    localparam logic [7:0] START_ADDR_DEF = 8'h00;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter and fetch sequencing: start/halt FSM, next-PC selection and
// cycle / retired-instruction counters.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF),
    parameter int              CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch_en,
    input  logic [PC_W-1:0]  branch_off,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [1:0]       state
);

    // Request semantics: halt/jump_en/branch_en are level requests sampled on
    // the edge; a stalled cycle drops jump/branch, so the requester keeps them
    // asserted until the first non-stalled cycle.

    pc_state_e       st_q;
    logic [PC_W-1:0] pc_adv;
    logic            cnt_clear;
    logic            cyc_inc;
    logic            ins_inc;

    assign state = st_q;

    // Branch offset is two's complement at PC_W bits, so a plain modulo add
    // already performs the sign-extended relative branch.
    always_comb begin
        pc_adv = pc + PC_W'(1);
        if (jump_en) begin
            pc_adv = jump_target;
        end else if (branch_en) begin
            pc_adv = pc + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= IDLE;
            pc      <= START_ADDR;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    pc <= START_ADDR;
                    if (start) begin
                        st_q    <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        st_q    <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc_adv;
                    end
                end
                DONE: begin
                    if (start) begin
                        st_q    <= RUN;
                        pc      <= START_ADDR;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    st_q    <= IDLE;
                    pc      <= START_ADDR;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // A halt cycle retires the halt instruction even if stall is also raised.
    assign cnt_clear = start && (st_q != RUN);
    assign cyc_inc   = (st_q == RUN);
    assign ins_inc   = (st_q == RUN) && (halt || !stall);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cyc_inc),
        .cnt   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (ins_inc),
        .cnt   (instr_cnt)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit; a second instance with 3-bit counters
// exercises counter saturation on the same stimulus.
module tb_pc_unit;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         EW     = 44;

    logic        clk = 1'b0;
    logic        reset, start, stall, halt, jump_en, branch_en;
    logic [7:0]  jump_target, branch_off;
    logic [7:0]  pc, pc_s;
    logic        running, done, running_s, done_s;
    logic [15:0] cycle_cnt, instr_cnt;
    logic [2:0]  cycle_cnt_s, instr_cnt_s;
    logic [1:0]  state, state_s;

    logic [EW-1:0] exp_q[$];
    logic [5:0]    sat_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            step  = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .jump_en(jump_en), .jump_target(jump_target), .branch_en(branch_en),
        .branch_off(branch_off), .pc(pc), .running(running), .done(done),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .state(state)
    );

    pc_unit #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .jump_en(jump_en), .jump_target(jump_target), .branch_en(branch_en),
        .branch_off(branch_off), .pc(pc_s), .running(running_s), .done(done_s),
        .cycle_cnt(cycle_cnt_s), .instr_cnt(instr_cnt_s), .state(state_s)
    );

    function automatic logic [2:0] sat3(input int x);
        return (x > 7) ? 3'd7 : 3'(x);
    endfunction

    task automatic drv(input logic rs, input logic s, input logic sl, input logic hl,
                       input logic je, input logic [7:0] jt,
                       input logic be, input logic [7:0] bo);
        reset = rs; start = s; stall = sl; halt = hl;
        jump_en = je; jump_target = jt; branch_en = be; branch_off = bo;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Expected state after the coming rising edge; checked on the next falling edge.
    task automatic tick(input logic [1:0] est, input logic [7:0] epc,
                        input int ecc, input int eic);
        @(posedge clk);
        #1;
        exp_q.push_back({est, (est == S_RUN), (est == S_DONE), epc, 16'(ecc), 16'(eic)});
        sat_q.push_back({sat3(ecc), sat3(eic)});
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [EW-1:0] e, a;
            logic [5:0]    es, as;
            e  = exp_q.pop_front();
            es = sat_q.pop_front();
            a  = {state, running, done, pc, cycle_cnt, instr_cnt};
            as = {cycle_cnt_s, instr_cnt_s};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL step%0d main: got st=%0d run=%b done=%b pc=%h cyc=%0d ins=%0d, want st=%0d run=%b done=%b pc=%h cyc=%0d ins=%0d",
                         step, a[43:42], a[41], a[40], a[39:32], a[31:16], a[15:0],
                         e[43:42], e[41], e[40], e[39:32], e[31:16], e[15:0]);
            end
            n_cmp++;
            if (as !== es) begin
                n_bad++;
                $display("FAIL step%0d sat3: got cyc=%0d ins=%0d, want cyc=%0d ins=%0d",
                         step, as[5:3], as[2:0], es[5:3], es[2:0]);
            end
            step++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        // reset state, start held high during reset is ignored
        tick(S_IDLE, 8'h00, 0, 0);
        tick(S_IDLE, 8'h00, 0, 0);
        idle();
        tick(S_IDLE, 8'h00, 0, 0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(S_RUN, 8'h00, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            idle();
            tick(S_RUN, 8'(i), i, i);
        end
        // relative branches, backward and forward across the wrap
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
        tick(S_RUN, 8'h10, 6, 6);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFC);
        tick(S_RUN, 8'h0C, 7, 7);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00);
        tick(S_RUN, 8'hFE, 8, 8);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05);
        tick(S_RUN, 8'h03, 9, 9);
        // jump beats branch; stall beats jump
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 8'h05);
        tick(S_RUN, 8'h40, 10, 10);
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 8'h00);
        tick(S_RUN, 8'h40, 11, 10);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 8'h00);
        tick(S_RUN, 8'h80, 12, 11);
        // free-run wrap 0xFF -> 0x00
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
        tick(S_RUN, 8'hFF, 13, 12);
        idle();
        tick(S_RUN, 8'h00, 14, 13);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00);
        tick(S_RUN, 8'h22, 15, 14);
        // halt wins over stall and still retires
        drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(S_DONE, 8'h22, 16, 15);
        idle();
        tick(S_DONE, 8'h22, 16, 15);
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 8'h07);
        tick(S_DONE, 8'h22, 16, 15);
        // restart from DONE; start during RUN is ignored
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(S_RUN, 8'h00, 0, 0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(S_RUN, 8'h01, 1, 1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h37, 1'b0, 8'h00);
        tick(S_RUN, 8'h37, 2, 2);
        // reset mid-RUN with start held
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(S_IDLE, 8'h00, 0, 0);
        idle();
        tick(S_IDLE, 8'h00, 0, 0);
        // long run to push the 3-bit counters into saturation
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(S_RUN, 8'h00, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            idle();
            tick(S_RUN, 8'(i), i, i);
        end
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(S_RUN, 8'h09, 10, 9);
        idle();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and fetch-control stage placed directly upstream of the instruction memory. Holds the 8-bit PC that addresses instruction memory, advances it each cycle, and applies relative branches, absolute jumps, stalls and halt from the decode/execute side. Also sequences program start/done for the testbench and keeps cycle and retired-instruction counters.

## Interface
Parameters:
- PC_W, 8, PC and jump-target width; instruction memory depth is 2**PC_W.
- START_ADDR, 8'h00, PC value loaded on reset and on start.
- CNT_W, 16, width of the cycle and instruction counters.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins execution from START_ADDR.
- stall  in  1  hold PC this cycle.
- halt  in  1  decoded halt instruction at current PC.
- jump_en  in  1  absolute jump request.
- jump_target  in  PC_W  absolute target.
- branch_en  in  1  taken relative branch.
- branch_off  in  PC_W  signed two's-complement offset, relative to current PC.
- pc  out  PC_W  current PC, addresses instruction memory.
- running  out  1  high in RUN state.
- done  out  1  high in DONE state.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- instr_cnt  out  CNT_W  instructions retired (non-stalled RUN cycles, incl. halt).

## Operation
- States: IDLE, RUN, DONE (encoding in package).
- IDLE: pc held at START_ADDR; counters held; start -> RUN, counters cleared to 0.
- RUN, per-cycle priority (highest first):
  - halt: pc held, instr_cnt+1, -> DONE.
  - stall: pc and instr_cnt held; jump_en/branch_en ignored (requester must hold them).
  - jump_en: pc <= jump_target.
  - branch_en: pc <= pc + branch_off, modulo 2**PC_W.
  - otherwise pc <= pc + 1, modulo 2**PC_W (255 -> 0 wraps silently).
  - instr_cnt+1 on every non-stalled cycle; cycle_cnt+1 on every RUN cycle incl. stall and halt cycle.
- start while RUN is ignored.
- DONE: pc, counters frozen; done=1; start -> RUN with pc=START_ADDR and counters cleared.
- Counters saturate at all-ones (no wrap).
- Branch arithmetic is PC_W-bit unsigned add of the sign-extended-to-PC_W offset; carry discarded.

## Timing
- Reset values: pc=START_ADDR, state=IDLE, running=0, done=0, cycle_cnt=0, instr_cnt=0.
- reset has priority over every input, including mid-RUN; takes effect on the next edge.
- pc is registered; instruction memory reads it combinationally; halt/jump/branch derived from that instruction are sampled at the next edge -> zero-bubble redirect, 1-cycle latency from request to new pc.
- running/done are decoded from the state register (registered, no combinational path from inputs).
- start -> running high next cycle; first instruction fetched at START_ADDR that cycle.
- halt -> done high next cycle; pc remains halt address.

## Structure
- Package pc_pkg: state enum (IDLE, RUN, DONE), default PC_W/CNT_W constants, START_ADDR default.
- Sub-module sat_counter (CNT_W, clear, inc, saturating), instantiated twice for cycle_cnt and instr_cnt.
- Next-PC mux and FSM in pc_unit itself.

## Test plan
- Reset then start, 5 free cycles -> pc 0,1,2,3,4,5; running=1; cycle_cnt=5, instr_cnt=5.
- At pc=0x10 branch_en with branch_off=0xFC (-4) -> next pc=0x0C; branch_off=0x05 at pc=0xFE -> pc=0x03 (wrap).
- jump_en=1, branch_en=1, jump_target=0x40 at same cycle -> pc=0x40 (jump wins); jump_en with stall=1 -> pc unchanged, instr_cnt unchanged, cycle_cnt+1.
- Free-run from 0xFF -> pc=0x00, no flag.
- halt at pc=0x22 with stall=1 -> done=1 next cycle, pc=0x22, counters frozen thereafter; start -> pc=0x00, counters 0, running=1.
- reset asserted mid-RUN at pc=0x37 -> next cycle pc=0x00, IDLE, all counters 0; start ignored while reset high.
